// File: rtl/data_mem_pkg.sv
// Shared constants, FSM state type and address helpers for the data memory responder.
package data_mem_pkg;

  localparam int BURST_LEN       = 8;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic logic [15:0] word_align(input logic [15:0] byte_addr);
    return byte_addr & 16'hFFFE;
  endfunction

  // A burst covers one 16-byte block, so its base drops the low nibble.
  function automatic logic [15:0] block_align(input logic [15:0] byte_addr);
    return byte_addr & 16'hFFF0;
  endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// Fixed-depth delay line carrying read beats (valid, address, data) toward the response port.
module mem_lat_pipe #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];

  // Only the valid bits need reset; payload is ignored wherever valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_q[0] <= in_addr;
    data_q[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      addr_q[i] <= addr_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with pipelined single reads, 8-beat block reads and
// single-word writes; read data is captured at issue and delayed to a fixed latency.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [15:0] resp_addr,
  output logic        err
);

  localparam logic [3:0] BURST_END = 4'(BURST_LEN);

  state_t      state;
  logic [3:0]  beat_cnt;
  logic [15:0] burst_base;
  logic [15:0] mem [2**ADDR_W];

  logic        accept;
  logic        wr_en;
  logic        issue_valid;
  logic [15:0] issue_addr;
  logic [15:0] issue_data;
  logic        pipe_valid;
  logic [15:0] pipe_addr;
  logic [15:0] pipe_data;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_wr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[req_addr[ADDR_W:1]] <= req_data;
    end
  end

  // Beat 0 of a burst goes out on the acceptance cycle; beats 1..7 follow from BURST.
  always_comb begin
    issue_valid = 1'b0;
    issue_addr  = word_align(req_addr);
    if (state == ST_IDLE) begin
      issue_valid = accept && !req_wr;
      if (req_burst) begin
        issue_addr = block_align(req_addr);
      end
    end else begin
      issue_valid = (beat_cnt != BURST_END);
      issue_addr  = burst_base + {11'b0, beat_cnt, 1'b0};
    end
  end

  // Reading at issue time makes a write on the previous cycle visible.
  assign issue_data = mem[issue_addr[ADDR_W:1]];

  // BURST lasts one cycle past the last issue, giving eight cycles of req_ready low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      burst_base <= '0;
    end else if (state == ST_IDLE) begin
      if (accept && !req_wr && req_burst) begin
        state      <= ST_BURST;
        beat_cnt   <= 4'd1;
        burst_base <= block_align(req_addr);
      end
    end else begin
      if (beat_cnt == BURST_END) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  mem_lat_pipe #(
    .DEPTH (LATENCY),
    .AW    (16),
    .DW    (16)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid),
    .in_addr   (issue_addr),
    .in_data   (issue_data),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .out_data  (pipe_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_addr  <= '0;
      err        <= 1'b0;
    end else begin
      resp_valid <= pipe_valid;
      if (pipe_valid) begin
        resp_data <= pipe_data;
        resp_addr <= pipe_addr;
      end
      err <= accept && req_addr[0];
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a transaction-level model predicts every output
// each cycle, and literal checks pin the model's expectations.
module tb_data_mem_resp;

  localparam int LAT   = 4;
  localparam int WORDS = 512;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr    = 1'b0;
  logic        req_burst = 1'b0;
  logic [15:0] req_addr  = '0;
  logic [15:0] req_data  = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [15:0] resp_addr;
  logic        err;

  data_mem_resp #(
    .ADDR_W  (9),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_burst  (req_burst),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] addr;
  } beat_t;

  beat_t       exp_q [$];
  logic [15:0] model_mem [WORDS];
  bit          err_at [int];
  int          cyc       = 0;
  int          busy_end  = 0;
  int          acc_edge  = 0;
  logic [15:0] base      = '0;
  beat_t       nb;
  logic [15:0] last_data = '0;
  logic [15:0] last_addr = '0;
  bit          exp_valid;
  int          n_cmp     = 0;
  int          n_fail    = 0;
  int          err_cnt   = 0;
  logic [15:0] log_data [$];
  logic [15:0] log_addr [$];
  int          log_cyc  [$];

  function automatic int word_index(input logic [15:0] a);
    return (int'(a) / 2) % WORDS;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit wr, input bit burst, input logic [15:0] addr, input logic [15:0] data);
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a request is taken whenever it is presented outside a burst window.
  always @(posedge clk) begin
    if (rst && req_valid && cyc >= busy_end) begin
      acc_edge = cyc + 1;
      if (req_addr[0]) err_at[acc_edge] = 1'b1;
      if (req_wr) begin
        model_mem[word_index(req_addr)] = req_data;
      end else if (req_burst) begin
        base = req_addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
          nb.due  = acc_edge + LAT + k;
          nb.addr = base + 16'(2 * k);
          nb.data = model_mem[word_index(nb.addr)];
          exp_q.push_back(nb);
        end
        busy_end = acc_edge + 8;
      end else begin
        nb.due  = acc_edge + LAT;
        nb.addr = req_addr & 16'hFFFE;
        nb.data = model_mem[word_index(req_addr)];
        exp_q.push_back(nb);
      end
    end
    cyc++;
  end

  always @(negedge rst) begin
    exp_q.delete();
    err_at.delete();
    busy_end  = 0;
    last_data = '0;
    last_addr = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_valid = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_valid = (exp_q[0].due == cyc);
        last_data = exp_q[0].data;
        last_addr = exp_q[0].addr;
        void'(exp_q.pop_front());
      end
      checkOutput("req_ready", {31'b0, req_ready}, {31'b0, cyc >= busy_end});
      checkOutput("err", {31'b0, err}, {31'b0, err_at.exists(cyc)});
      checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
      checkOutput("resp_data", {16'b0, resp_data}, {16'b0, last_data});
      checkOutput("resp_addr", {16'b0, resp_addr}, {16'b0, last_addr});
      if (resp_valid) begin
        log_data.push_back(resp_data);
        log_addr.push_back(resp_addr);
        log_cyc.push_back(cyc);
      end
      if (err) err_cnt++;
    end
  end

  int acc;
  int low_cnt;

  initial begin
    $display("[TB] start");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_data", {16'b0, resp_data}, 32'd0);
    checkOutput("rst_resp_addr", {16'b0, resp_addr}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", {31'b0, req_ready}, 32'd1);

    $display("[TB] write then single read");
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    acc = cyc;
    waitCycles(6);
    checkOutput("t1_beats", log_data.size(), 32'd1);
    checkOutput("t1_data", {16'b0, log_data[0]}, 32'h0000BEEF);
    checkOutput("t1_addr", {16'b0, log_addr[0]}, 32'h00000000);
    checkOutput("t1_latency", log_cyc[0] - acc, 32'd4);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 1'b0, 16'h0002, 16'hDEAD);
    applyStimulus(1'b0, 1'b0, 16'h0002, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    waitCycles(6);
    checkOutput("t2_beats", log_data.size(), 32'd3);
    checkOutput("t2_data0", {16'b0, log_data[1]}, 32'h0000DEAD);
    checkOutput("t2_addr0", {16'b0, log_addr[1]}, 32'h00000002);
    checkOutput("t2_data1", {16'b0, log_data[2]}, 32'h0000BEEF);
    checkOutput("t2_consecutive", log_cyc[2] - log_cyc[1], 32'd1);

    $display("[TB] misaligned burst read");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0010 + 16'(2 * i), 16'h1000 + 16'(i));
    end
    applyStimulus(1'b0, 1'b1, 16'h0013, 16'h0000);
    acc = cyc;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_burst = 1'b0;
    req_addr  = 16'h0010;
    req_data  = 16'hFFFF;
    low_cnt   = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (!req_ready) low_cnt++;
      if (k == 7) req_valid = 1'b0;
    end
    checkOutput("t3_ready_low_cycles", low_cnt, 32'd8);
    @(posedge clk);
    #1;
    waitCycles(6);
    checkOutput("t3_beats", log_data.size(), 32'd11);
    for (int k = 0; k < 8; k++) begin
      checkOutput("t3_data", {16'b0, log_data[3+k]}, 32'h1000 + k);
      checkOutput("t3_addr", {16'b0, log_addr[3+k]}, 32'h0010 + 2 * k);
    end
    checkOutput("t3_first_latency", log_cyc[3] - acc, 32'd4);
    checkOutput("t3_span", log_cyc[10] - log_cyc[3], 32'd7);

    $display("[TB] misaligned single read");
    applyStimulus(1'b0, 1'b0, 16'h0003, 16'h0000);
    acc = cyc;
    waitCycles(6);
    checkOutput("t4_beats", log_data.size(), 32'd12);
    checkOutput("t4_data", {16'b0, log_data[11]}, 32'h0000DEAD);
    checkOutput("t4_addr", {16'b0, log_addr[11]}, 32'h00000002);
    checkOutput("t4_latency", log_cyc[11] - acc, 32'd4);
    checkOutput("t4_err_pulses", err_cnt, 32'd2);

    $display("[TB] reset during burst");
    applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0000);
    repeat (6) @(posedge clk);
    #3;
    checkOutput("t5_third_beat_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("t5_third_beat_data", {16'b0, resp_data}, 32'h00001002);
    rst = 1'b0;
    #1;
    checkOutput("t5_valid_in_reset", {31'b0, resp_valid}, 32'd0);
    checkOutput("t5_data_in_reset", {16'b0, resp_data}, 32'd0);
    checkOutput("t5_ready_in_reset", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_ready_after_release", {31'b0, req_ready}, 32'd1);
    waitCycles(12);
    checkOutput("t5_beats", log_data.size(), 32'd14);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b0, 16'h0400, 16'h5A5A);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    acc = cyc;
    waitCycles(6);
    checkOutput("t6_beats", log_data.size(), 32'd15);
    checkOutput("t6_data", {16'b0, log_data[14]}, 32'h00005A5A);
    checkOutput("t6_addr", {16'b0, log_addr[14]}, 32'h00000000);
    checkOutput("t6_latency", log_cyc[14] - acc, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter: ADDR_W, default 9, word-address width (2^ADDR_W 16-bit words of storage).
REQ-002 Parameter: LATENCY, default 4, cycles from read acceptance to resp_valid.
REQ-003 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-low reset.
REQ-005 Port: req_valid, input, 1, request present.
REQ-006 Port: req_wr, input, 1, 1 = single-word write, 0 = read.
REQ-007 Port: req_burst, input, 1, 1 = 8-word block read (ignored when req_wr=1).
REQ-008 Port: req_addr, input, 16, byte address.
REQ-009 Port: req_data, input, 16, write data.
REQ-010 Port: req_ready, output, 1, request accepted this cycle when req_valid && req_ready.
REQ-011 Port: resp_valid, output, 1, read-data beat valid (one-cycle pulse per beat).
REQ-012 Port: resp_data, output, 16, read data.
REQ-013 Port: resp_addr, output, 16, word-aligned byte address of the beat.
REQ-014 Port: err, output, 1, one-cycle pulse when an accepted request has req_addr[0]=1.

Function
REQ-015 Word index = req_addr[ADDR_W:1]; bit 0 and bits above ADDR_W are ignored (address wraps modulo memory size).
REQ-016 A misaligned request SHALL still execute with bit 0 cleared; err pulses the cycle after acceptance.
REQ-017 FSM states IDLE and BURST; reset state IDLE; req_ready=1 in IDLE, 0 in BURST.
REQ-018 Write: on acceptance the word is committed at that clock edge; there is no response beat.
REQ-019 Single read: accepted in IDLE; one beat with resp_valid exactly LATENCY cycles after the acceptance edge; data reflects all writes accepted before it.
REQ-020 Reads and writes SHALL be pipelined: one request accepted per cycle in IDLE; responses return in acceptance order.
REQ-021 Burst read: base = req_addr with bits [3:0] cleared; FSM enters BURST; 8 beats for words base, base+2, ... base+14 SHALL appear on 8 consecutive cycles, the first LATENCY cycles after acceptance.
REQ-022 The FSM returns to IDLE the cycle after the 8th beat address is issued into the pipeline; req_ready then reasserts.
REQ-023 Single-read beats accepted before a burst SHALL complete normally, ahead of the burst beats.
REQ-024 A write to word X followed by a read of X on the next cycle SHALL return the new data.
REQ-025 When resp_valid=0, resp_data and resp_addr hold their last values.

Reset
REQ-026 On rst low (asynchronous): FSM to IDLE, all pipeline valid bits cleared, resp_valid=0, err=0, resp_data=0, resp_addr=0, burst counter=0.
REQ-027 Reset mid-burst or with reads in flight discards them; no beat appears after rst deasserts without a new request.
REQ-028 Memory contents are not initialised by reset.
REQ-029 req_ready=1 on the first edge after rst deasserts.

Structure
REQ-030 Package data_mem_pkg holds BURST_LEN=8, the FSM state enum, and the default LATENCY.
REQ-031 Sub-module mem_lat_pipe: LATENCY-deep valid/addr/data shift register, async active-low reset on valid bits only.

Verification
REQ-032 Write 0xBEEF @0x0000, then read 0x0000 -> resp_valid 4 cycles after read acceptance, resp_data=0xBEEF, resp_addr=0x0000.
REQ-033 Write 0xDEAD @0x0002; read 0x0002 and 0x0000 back-to-back -> consecutive beats 0xDEAD, then 0xBEEF.
REQ-034 Write words 0x1000+i to 0x0010+2i (i=0..7), burst read @0x0013 -> req_ready low 8 cycles, 8 consecutive beats 0x1000..0x1007, addrs 0x0010..0x001E.
REQ-035 Read @0x0003 -> err pulse, beat returns word at 0x0002 (0xDEAD).
REQ-036 Assert rst during the 3rd burst beat -> resp_valid 0 immediately and stays 0 after release; req_ready=1.
REQ-037 Write 0x5A5A @0x0400 with ADDR_W=9 -> read @0x0000 returns 0x5A5A (wrap).
